// File: rtl/atb_vector_loader.sv
// Loads four signed A/B element pairs into a dot-product engine, runs it and hands back the result.
// Optional macro ATB_LOADER_TIMEOUT_EN adds a 32-cycle RUN watchdog with a sticky err flag.
module atb_vector_loader #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             atb_rst,
    output logic             atb_start,
    output logic [N-1:0]     atb_a0,
    output logic [N-1:0]     atb_a1,
    output logic [N-1:0]     atb_a2,
    output logic [N-1:0]     atb_a3,
    output logic [N-1:0]     atb_b0,
    output logic [N-1:0]     atb_b1,
    output logic [N-1:0]     atb_b2,
    output logic [N-1:0]     atb_b3,
    input  logic             atb_done,
    input  logic [2*N+1:0]   atb_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N+1:0]   out_y,
    output logic             busy,
    output logic             err
);

    localparam int unsigned YW = 2 * N + 2;
    localparam int unsigned EW = 2;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   elem_q, elem_d;
    logic [N-1:0]    a_q [4];
    logic [N-1:0]    b_q [4];
    logic            in_ready_q, in_ready_d;
    logic            atb_rst_q, atb_rst_d;
    logic            atb_start_q, atb_start_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [YW-1:0]   out_y_q, out_y_d;
    logic            accept;
    logic            timeout;

    assign accept = in_valid && in_ready_q;

`ifdef ATB_LOADER_TIMEOUT_EN
    logic [5:0] run_cnt_q, run_cnt_d;
    logic       err_q, err_d;

    // Counts RUN cycles; cleared in every other state so each run starts from zero.
    assign run_cnt_d = (state_q == S_RUN) ? 6'(run_cnt_q + 6'd1) : 6'd0;
    assign timeout   = (state_q == S_RUN) && !atb_done && (run_cnt_q == 6'd31);
    assign err_d     = err_q || timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q <= 6'd0;
            err_q     <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: if (accept && (elem_q == EW'(3))) state_d = S_CLR;
            S_CLR:  state_d = S_RUN;
            S_RUN: begin
                if (atb_done)     state_d = S_OUT;
                else if (timeout) state_d = S_LOAD;
            end
            S_OUT:  if (out_ready) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        in_ready_d  = (state_d == S_LOAD);
        atb_rst_d   = (state_d == S_CLR);
        atb_start_d = (state_d == S_RUN);
        busy_d      = (state_d != S_LOAD);
        out_valid_d = (state_d == S_OUT);
        out_y_d     = out_y_q;
        elem_d      = elem_q;
        if ((state_q == S_RUN) && atb_done) out_y_d = atb_y;
        if (accept)                         elem_d  = EW'(elem_q + EW'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q  <= 1'b1;
            atb_rst_q   <= 1'b1;
            atb_start_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            elem_q      <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            atb_rst_q   <= atb_rst_d;
            atb_start_q <= atb_start_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            elem_q      <= elem_d;
        end
    end

    // Operand registers: only a handshaked beat in LOAD may overwrite them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (accept) begin
            a_q[elem_q] <= in_a;
            b_q[elem_q] <= in_b;
        end
    end

    assign in_ready  = in_ready_q;
    assign atb_rst   = atb_rst_q;
    assign atb_start = atb_start_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign atb_a0    = a_q[0];
    assign atb_a1    = a_q[1];
    assign atb_a2    = a_q[2];
    assign atb_a3    = a_q[3];
    assign atb_b0    = b_q[0];
    assign atb_b1    = b_q[1];
    assign atb_b2    = b_q[2];
    assign atb_b3    = b_q[3];

endmodule
